// File: rtl/iq_stream_join_if.sv
// iq_stream_join_if: I input, Q input and joined {I,Q} output stream bundles.
// The join block uses the slave modport; the stream source/sink uses master.
interface iq_stream_join_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   i_tdata;
    logic               i_tlast;
    logic               i_tvalid;
    logic               i_tready;
    logic [WIDTH-1:0]   q_tdata;
    logic               q_tlast;
    logic               q_tvalid;
    logic               q_tready;
    logic [2*WIDTH-1:0] o_tdata;
    logic               o_tlast;
    logic               o_tvalid;
    logic               o_tready;

    modport master (
        output i_tdata, i_tlast, i_tvalid, q_tdata, q_tlast, q_tvalid, o_tready,
        input  i_tready, q_tready, o_tdata, o_tlast, o_tvalid
    );

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, q_tdata, q_tlast, q_tvalid, o_tready,
        output i_tready, q_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

// File: rtl/iq_stream_join.sv
// iq_stream_join: buffers I/Q skew in per-channel FIFOs, pops them in lock-step into one
// {I,Q} stream reframed to spp samples, reports skew and flags deadlock.
// Define IQ_STREAM_JOIN_AUTOFLUSH_EN to drop the full FIFO automatically after a deadlock.
module iq_stream_join #(
    parameter int WIDTH        = 16,
    parameter int FIFO_SIZE    = 10,
    parameter int SPP_WIDTH    = 16,
    parameter int DEADLOCK_CYC = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    iq_stream_join_if.slave             bus,
    input  logic [SPP_WIDTH-1:0]        spp,
    output logic signed [FIFO_SIZE+1:0] skew,
    output logic                        deadlock_err
);
    localparam int DEPTH = 1 << FIFO_SIZE;
    localparam int DLW   = $clog2(DEADLOCK_CYC + 1);
    localparam logic [FIFO_SIZE:0]   CNT_FULL = (FIFO_SIZE+1)'(DEPTH);
    localparam logic [FIFO_SIZE:0]   CNT_ONE  = (FIFO_SIZE+1)'(1);
    localparam logic [FIFO_SIZE-1:0] PTR_ONE  = FIFO_SIZE'(1);
    localparam logic [SPP_WIDTH-1:0] SPP_ONE  = SPP_WIDTH'(1);
    localparam logic [DLW-1:0]       DL_ONE   = DLW'(1);
    localparam logic [DLW-1:0]       DL_LAST  = DLW'(DEADLOCK_CYC - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    logic [WIDTH:0]         mem_i_q [DEPTH];
    logic [WIDTH:0]         mem_q_q [DEPTH];
    logic [FIFO_SIZE-1:0]   wr_ptr_i_q, wr_ptr_i_d, rd_ptr_i_q, rd_ptr_i_d;
    logic [FIFO_SIZE-1:0]   wr_ptr_q_q, wr_ptr_q_d, rd_ptr_q_q, rd_ptr_q_d;
    logic [FIFO_SIZE:0]     cnt_i_q, cnt_i_d, cnt_q_q, cnt_q_d;
    logic                   rdy_en_q, rdy_en_d;
    logic                   o_valid_q, o_valid_d, o_last_q, o_last_d;
    logic [2*WIDTH-1:0]     o_data_q, o_data_d;
    logic [SPP_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic signed [FIFO_SIZE+1:0] skew_q, skew_d;
    state_t                 state_q, state_d;
    logic [DLW-1:0]         dl_cnt_q, dl_cnt_d;
    logic                   err_q, err_d;

    logic full_i_s, full_q_s, empty_i_s, empty_q_s;
    logic rdy_i_s, rdy_q_s, wr_i_s, wr_q_s, pop_s, dl_cond_s;
    logic flush_i_s, flush_q_s;
    logic [WIDTH:0] head_i_s, head_q_s;

    // Status flags, handshakes and the lock-step pop decision
    always_comb begin
        full_i_s  = (cnt_i_q == CNT_FULL);
        full_q_s  = (cnt_q_q == CNT_FULL);
        empty_i_s = (cnt_i_q == '0);
        empty_q_s = (cnt_q_q == '0);
        rdy_i_s   = rdy_en_q & ~full_i_s;
        rdy_q_s   = rdy_en_q & ~full_q_s;
        wr_i_s    = bus.i_tvalid & rdy_i_s & ~clear;
        wr_q_s    = bus.q_tvalid & rdy_q_s & ~clear;
        pop_s     = ~empty_i_s & ~empty_q_s & (~o_valid_q | bus.o_tready);
        dl_cond_s = (full_i_s & empty_q_s) | (full_q_s & empty_i_s);
        head_i_s  = mem_i_q[rd_ptr_i_q];
        head_q_s  = mem_q_q[rd_ptr_q_q];
        rdy_en_d  = 1'b1;
`ifdef IQ_STREAM_JOIN_AUTOFLUSH_EN
        flush_i_s = (state_q == ST_STALL) & full_i_s;
        flush_q_s = (state_q == ST_STALL) & full_q_s;
`else
        flush_i_s = 1'b0;
        flush_q_s = 1'b0;
`endif
    end

    // I FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_i_d = wr_ptr_i_q;
        rd_ptr_i_d = rd_ptr_i_q;
        cnt_i_d    = cnt_i_q;
        if (clear || flush_i_s) begin
            wr_ptr_i_d = '0;
            rd_ptr_i_d = '0;
            cnt_i_d    = '0;
        end else begin
            if (wr_i_s) wr_ptr_i_d = wr_ptr_i_q + PTR_ONE;
            else        wr_ptr_i_d = wr_ptr_i_q;
            if (pop_s)  rd_ptr_i_d = rd_ptr_i_q + PTR_ONE;
            else        rd_ptr_i_d = rd_ptr_i_q;
            case ({wr_i_s, pop_s})
                2'b10:   cnt_i_d = cnt_i_q + CNT_ONE;
                2'b01:   cnt_i_d = cnt_i_q - CNT_ONE;
                default: cnt_i_d = cnt_i_q;
            endcase
        end
    end

    // Q FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_q_d = wr_ptr_q_q;
        rd_ptr_q_d = rd_ptr_q_q;
        cnt_q_d    = cnt_q_q;
        if (clear || flush_q_s) begin
            wr_ptr_q_d = '0;
            rd_ptr_q_d = '0;
            cnt_q_d    = '0;
        end else begin
            if (wr_q_s) wr_ptr_q_d = wr_ptr_q_q + PTR_ONE;
            else        wr_ptr_q_d = wr_ptr_q_q;
            if (pop_s)  rd_ptr_q_d = rd_ptr_q_q + PTR_ONE;
            else        rd_ptr_q_d = rd_ptr_q_q;
            case ({wr_q_s, pop_s})
                2'b10:   cnt_q_d = cnt_q_q + CNT_ONE;
                2'b01:   cnt_q_d = cnt_q_q - CNT_ONE;
                default: cnt_q_d = cnt_q_q;
            endcase
        end
    end

    // Output register and packet framing; a lowered spp forces tlast on the next sample
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_last_d  = o_last_q;
        pkt_cnt_d = pkt_cnt_q;
        if (clear) begin
            o_valid_d = 1'b0;
            o_data_d  = '0;
            o_last_d  = 1'b0;
            pkt_cnt_d = '0;
        end else if (pop_s) begin
            o_valid_d = 1'b1;
            o_data_d  = {head_i_s[WIDTH-1:0], head_q_s[WIDTH-1:0]};
            if (spp == '0) begin
                o_last_d  = head_i_s[WIDTH] | head_q_s[WIDTH];
                pkt_cnt_d = '0;
            end else if (pkt_cnt_q >= spp - SPP_ONE) begin
                o_last_d  = 1'b1;
                pkt_cnt_d = '0;
            end else begin
                o_last_d  = 1'b0;
                pkt_cnt_d = pkt_cnt_q + SPP_ONE;
            end
        end else if (bus.o_tready) begin
            o_valid_d = 1'b0;
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    // Deadlock FSM and skew, computed from post-update occupancies
    always_comb begin
        state_d  = state_q;
        dl_cnt_d = dl_cnt_q;
        err_d    = err_q;
        skew_d   = $signed({1'b0, cnt_i_d}) - $signed({1'b0, cnt_q_d});
        if (clear) begin
            state_d  = ST_RUN;
            dl_cnt_d = '0;
            err_d    = 1'b0;
            skew_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!dl_cond_s) begin
                        dl_cnt_d = '0;
                    end else if (dl_cnt_q == DL_LAST) begin
                        state_d  = ST_STALL;
                        err_d    = 1'b1;
                        dl_cnt_d = '0;
                    end else begin
                        dl_cnt_d = dl_cnt_q + DL_ONE;
                    end
                end
                ST_STALL: begin
                    dl_cnt_d = '0;
`ifdef IQ_STREAM_JOIN_AUTOFLUSH_EN
                    state_d = ST_RUN;
`else
                    if (!empty_i_s && !empty_q_s) state_d = ST_RUN;
                    else                          state_d = ST_STALL;
`endif
                end
                default: begin
                    state_d  = ST_RUN;
                    dl_cnt_d = '0;
                end
            endcase
        end
    end

    // Sample storage; entries are only read after being written, so no reset
    always_ff @(posedge clk) begin
        if (wr_i_s) mem_i_q[wr_ptr_i_q] <= {bus.i_tlast, bus.i_tdata};
        if (wr_q_s) mem_q_q[wr_ptr_q_q] <= {bus.q_tlast, bus.q_tdata};
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_i_q <= '0;
            rd_ptr_i_q <= '0;
            cnt_i_q    <= '0;
            wr_ptr_q_q <= '0;
            rd_ptr_q_q <= '0;
            cnt_q_q    <= '0;
            rdy_en_q   <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_last_q   <= 1'b0;
            pkt_cnt_q  <= '0;
            skew_q     <= '0;
            state_q    <= ST_RUN;
            dl_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_i_q <= wr_ptr_i_d;
            rd_ptr_i_q <= rd_ptr_i_d;
            cnt_i_q    <= cnt_i_d;
            wr_ptr_q_q <= wr_ptr_q_d;
            rd_ptr_q_q <= rd_ptr_q_d;
            cnt_q_q    <= cnt_q_d;
            rdy_en_q   <= rdy_en_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_last_q   <= o_last_d;
            pkt_cnt_q  <= pkt_cnt_d;
            skew_q     <= skew_d;
            state_q    <= state_d;
            dl_cnt_q   <= dl_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.i_tready  = rdy_i_s;
    assign bus.q_tready  = rdy_q_s;
    assign bus.o_tdata   = o_data_q;
    assign bus.o_tlast   = o_last_q;
    assign bus.o_tvalid  = o_valid_q;
    assign skew          = skew_q;
    assign deadlock_err  = err_q;
endmodule

// File: tb/tb_iq_stream_join.sv
// tb_iq_stream_join: randomized scoreboard bench for iq_stream_join (FIFO_SIZE=3).
// The reference model pairs accepted I/Q samples in order and frames them from spp.
`timescale 1ns/1ps
module tb_iq_stream_join;
    localparam int W  = 16;
    localparam int FS = 3;
    localparam int SW = 16;
    localparam int DC = 16;

    logic clk = 1'b0;
    logic reset_n, clear;
    logic [SW-1:0] spp;
    logic signed [FS+1:0] skew;
    logic deadlock_err;

    iq_stream_join_if #(.WIDTH(W)) bus ();

    iq_stream_join #(.WIDTH(W), .FIFO_SIZE(FS), .SPP_WIDTH(SW), .DEADLOCK_CYC(DC)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus),
        .spp(spp), .skew(skew), .deadlock_err(deadlock_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W:0]   i_src[$], q_src[$], mdl_i[$], mdl_q[$];
    logic [2*W:0] exp_q[$];
    int pos = 0;
    int rdy_mode = 0;
    int rdy_cyc = 0;
    int skew_max = 0;
    int skew_min = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // model: output n pairs sample n of I with sample n of Q
    task automatic build_exp();
        logic [W:0] a, b;
        logic l;
        while (mdl_i.size() > 0 && mdl_q.size() > 0) begin
            a = mdl_i.pop_front();
            b = mdl_q.pop_front();
            if (spp == '0) begin
                l = a[W] | b[W];
                pos = 0;
            end else begin
                l = (pos + 1 >= int'(spp));
                pos = l ? 0 : pos + 1;
            end
            exp_q.push_back({l, a[W-1:0], b[W-1:0]});
        end
    endtask

    task automatic load(int n, int mode, int tl_idx);
        logic [W-1:0] di, dq;
        logic li, lq;
        for (int k = 0; k < n; k++) begin
            if (mode == 0) begin
                di = W'(k);
                dq = W'(256 + k);
                li = (k == tl_idx);
                lq = li;
            end else begin
                di = W'($urandom);
                dq = W'($urandom);
                li = ($urandom_range(0, 9) == 0);
                lq = ($urandom_range(0, 9) == 0);
            end
            i_src.push_back({li, di});
            q_src.push_back({lq, dq});
        end
    endtask

    task automatic drive(int q_delay, int vpct, int max_cyc);
        int cyc = 0;
        while ((i_src.size() > 0 || q_src.size() > 0) && cyc < max_cyc) begin
            @(negedge clk);
            bus.i_tvalid = (i_src.size() > 0) && (int'($urandom_range(0, 99)) < vpct);
            bus.q_tvalid = (q_src.size() > 0) && (cyc >= q_delay) && (int'($urandom_range(0, 99)) < vpct);
            if (i_src.size() > 0) {bus.i_tlast, bus.i_tdata} = i_src[0];
            if (q_src.size() > 0) {bus.q_tlast, bus.q_tdata} = q_src[0];
            if (bus.i_tvalid && bus.i_tready) mdl_i.push_back(i_src.pop_front());
            if (bus.q_tvalid && bus.q_tready) mdl_q.push_back(q_src.pop_front());
            build_exp();
            if (int'(skew) > skew_max) skew_max = int'(skew);
            if (int'(skew) < skew_min) skew_min = int'(skew);
            cyc++;
        end
        check("drive_timeout", i_src.size() + q_src.size(), 0);
        @(negedge clk);
        bus.i_tvalid = 1'b0;
        bus.q_tvalid = 1'b0;
    endtask

    task automatic wait_drain(int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain", exp_q.size(), 0);
        check("unpaired", mdl_i.size() + mdl_q.size(), 0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        mdl_i.delete(); mdl_q.delete(); exp_q.delete();
        pos = 0;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clr_valid", bus.o_tvalid, 0);
        check("clr_skew", skew, 0);
        check("clr_err", deadlock_err, 0);
    endtask

    // downstream ready pattern
    initial begin
        bus.o_tready = 1'b0;
        forever begin
            @(negedge clk);
            rdy_cyc++;
            case (rdy_mode)
                0:       bus.o_tready = 1'b1;
                1:       bus.o_tready = rdy_cyc[0];
                2:       bus.o_tready = 1'($urandom_range(0, 1));
                default: bus.o_tready = 1'b0;
            endcase
        end
    end

    // monitor: scoreboard compare on each transfer plus hold-under-backpressure
    initial begin
        logic [2*W-1:0] prev_data;
        logic prev_stall, prev_clr;
        logic [2*W:0] e;
        prev_stall = 1'b0;
        prev_clr = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && !prev_clr && prev_stall) begin
                check("hold_valid", bus.o_tvalid, 1);
                check("hold_data", bus.o_tdata, prev_data);
            end
            if (reset_n && bus.o_tvalid && bus.o_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got %0h expected nothing", bus.o_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.o_tdata, e[2*W-1:0]);
                    check("out_last", bus.o_tlast, e[2*W]);
                end
            end
            prev_stall = reset_n && bus.o_tvalid && !bus.o_tready;
            prev_data = bus.o_tdata;
            prev_clr = clear;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_n = 1'b0; clear = 1'b0; spp = '0;
        bus.i_tvalid = 1'b0; bus.i_tdata = '0; bus.i_tlast = 1'b0;
        bus.q_tvalid = 1'b0; bus.q_tdata = '0; bus.q_tlast = 1'b0;
        #1;
        check("rst_valid", bus.o_tvalid, 0);
        check("rst_last", bus.o_tlast, 0);
        check("rst_data", bus.o_tdata, 0);
        check("rst_skew", skew, 0);
        check("rst_err", deadlock_err, 0);
        check("rst_irdy", bus.i_tready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("rel_irdy0", bus.i_tready, 0);
        @(negedge clk);
        #1;
        check("rel_irdy1", bus.i_tready, 1);
        check("rel_qrdy1", bus.q_tready, 1);

        // equal delay, latency 2, skew 0
        rdy_mode = 0; skew_max = 0; skew_min = 0;
        load(8, 0, -1);
        fork
            drive(0, 100, 100);
            begin
                @(negedge clk); #2;
                lat = 0;
                while (!bus.o_tvalid && lat < 10) begin
                    @(negedge clk); #2;
                    lat++;
                end
                check("latency", lat, 2);
            end
        join
        wait_drain(50);
        check("t1_skew_max", skew_max, 0);
        check("t1_skew_min", skew_min, 0);

        // Q lags I by 5 samples
        do_clear();
        skew_max = 0; skew_min = 0;
        load(8, 1, -1);
        drive(5, 100, 100);
        wait_drain(50);
        check("t2_skew_peak", skew_max, 5);
        check("t2_skew_min", skew_min, 0);

        // spp=4 reframing, input tlast on sample 1 ignored
        do_clear();
        spp = 16'd4;
        load(10, 0, 1);
        drive(0, 100, 100);
        wait_drain(50);

        // lowering spp below the current count forces tlast
        do_clear();
        spp = 16'd8;
        load(5, 1, -1);
        drive(0, 100, 100);
        wait_drain(50);
        spp = 16'd3;
        load(4, 1, -1);
        drive(0, 100, 100);
        wait_drain(50);

        // 1010 backpressure
        do_clear();
        spp = 16'd0; rdy_mode = 1;
        load(20, 1, -1);
        drive(0, 100, 200);
        wait_drain(100);

        // randomized traffic and framing
        rdy_mode = 2;
        for (int r = 0; r < 4; r++) begin
            spp = SW'($urandom_range(0, 5));
            load(40, 1, -1);
            drive(0, 60, 600);
            wait_drain(400);
            check("rand_no_deadlock", deadlock_err, 0);
        end

        // deadlock: I only
        rdy_mode = 0;
        do_clear();
        spp = 16'd0;
        for (int k = 0; k < 8; k++) i_src.push_back({1'b0, W'(16'h0A00 + k)});
        drive(0, 100, 50);
        #1;
        check("t5_irdy_full", bus.i_tready, 0);
        check("t5_accepted", mdl_i.size(), 8);
        repeat (15) @(negedge clk);
        #1 check("t5_err_early", deadlock_err, 0);
        @(negedge clk);
        #1;
        check("t5_err_set", deadlock_err, 1);
        check("t5_skew_full", skew, 8);
        @(negedge clk);
        #1;
`ifdef IQ_STREAM_JOIN_AUTOFLUSH_EN
        check("t5_flush_skew", skew, 0);
        check("t5_flush_irdy", bus.i_tready, 1);
        check("t5_err_sticky", deadlock_err, 1);
        mdl_i.delete();
`else
        check("t5_stall_skew", skew, 8);
        for (int k = 0; k < 8; k++) q_src.push_back({1'b0, W'($urandom)});
        drive(0, 100, 50);
        wait_drain(50);
        check("t5_err_sticky", deadlock_err, 1);
`endif
        do_clear();

        // async reset mid-stream
        spp = 16'd0; rdy_mode = 0;
        load(20, 1, -1);
        fork
            drive(0, 100, 200);
            begin
                repeat (6) @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                check("mid_rst_valid", bus.o_tvalid, 0);
                check("mid_rst_data", bus.o_tdata, 0);
                check("mid_rst_last", bus.o_tlast, 0);
                check("mid_rst_skew", skew, 0);
                check("mid_rst_irdy", bus.i_tready, 0);
                check("mid_rst_qrdy", bus.q_tready, 0);
                i_src.delete(); q_src.delete();
                mdl_i.delete(); mdl_q.delete(); exp_q.delete();
                pos = 0;
            end
        join
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1 check("post_rst_irdy", bus.i_tready, 1);

        // clear mid-packet with stale data held in the output register
        spp = 16'd4; rdy_mode = 3;
        load(6, 1, -1);
        drive(0, 100, 50);
        repeat (2) @(negedge clk);
        do_clear();
        rdy_mode = 0;
        load(4, 0, -1);
        drive(0, 100, 50);
        wait_drain(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
